aes_state_io: RTL
=================

Name: aes_state_io

Overview:
Block I/O controller for the AES state matrix.
- Accepts a 128-bit block as four 32-bit column words over a valid/ready stream and writes them into the state matrix through its column-write port.
- On request, reads the four columns back and streams them out over a valid/ready stream.
- Sits between the host-side block interface and the state matrix storage; round-processing stages use the matrix while this block is in FULL.

Parameters:
AUTO_UNLOAD, 0, 1 = FULL enters unload immediately without waiting for unload_start; 0 = wait for unload_start.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
in_data  in  32  column word; word k loads column k
in_valid  in  1  in_data valid
in_ready  out  1  block can accept a word this cycle
load_done  out  1  one-cycle pulse: fourth word written, matrix full
unload_start  in  1  request to stream the matrix out (sampled only in FULL)
out_data  out  32  column word being returned; word k = column k
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
unload_done  out  1  one-cycle pulse: fourth word handed off
busy  out  1  high unless in LOAD with cnt==0
mat_col_in  out  32  to matrix col_in
mat_idx  out  2  to matrix idx
mat_row_col  out  1  to matrix row_col; constant 1 (column access)
mat_read_write  out  1  to matrix read_write
mat_write_enable  out  1  to matrix write_enable
mat_out  in  32  from matrix out (combinational read data)

Behaviour:
- Registers: state (LOAD, FULL, UNLOAD), 2-bit cnt, out_data, out_valid, load_done, unload_done.
- Reset values: state=LOAD, cnt=0, out_data=0, out_valid=0, load_done=0, unload_done=0; therefore in_ready=1 and busy=0.
- Reset mid-load or mid-unload discards the partial block. Matrix contents are not cleared.

Matrix drive (combinational):
- mat_row_col=1 always.
- Accept cycle (state==LOAD && in_valid && in_ready): mat_write_enable=1, mat_read_write=1, mat_idx=cnt, mat_col_in=in_data.
- All other cycles: mat_write_enable=0, mat_read_write=0 (read), mat_col_in=0.
- mat_idx for reads:
  - FULL: mat_idx=0.
  - UNLOAD: mat_idx=cnt+1 (wraps to 0 when cnt=3).

LOAD:
- in_ready=1.
- Each accept writes column cnt in the same cycle and increments cnt.
- Accept with cnt==3: cnt<=0, state<=FULL, load_done=1 next cycle.
- in_valid low leaves cnt unchanged; there is no timeout.

FULL:
- in_ready=0.
- Start condition: unload_start==1, or AUTO_UNLOAD==1.
- On start: out_data<=mat_out (column 0), out_valid<=1, cnt<=0, state<=UNLOAD.
- Latency: first word is valid 1 cycle after the start cycle.

UNLOAD:
- in_ready=0. unload_start is ignored.
- out_valid && out_ready && cnt<3: out_data<=mat_out (column cnt+1), cnt<=cnt+1, out_valid stays 1. Throughput is one word per cycle.
- out_valid && out_ready && cnt==3: out_valid<=0, cnt<=0, state<=LOAD, unload_done=1 next cycle.
- out_ready low: out_data and out_valid hold.

Other rules:
- load_done and unload_done are single-cycle pulses, registered.
- Stream inputs are ignored outside their phase: in_valid outside LOAD, out_ready when out_valid=0.
- in_valid asserted while FULL or UNLOAD is not accepted and writes nothing.

Test Plan:
1. Reset then load words 00112233, 44556677, 8899aabb, ccddeeff with in_valid held high → four consecutive write cycles with mat_idx 0,1,2,3; load_done pulse on the cycle after the 4th; in_ready=0; busy=1.
2. From FULL, pulse unload_start with out_ready=1 → out_valid rises next cycle; out_data is 00112233, 44556677, 8899aabb, ccddeeff on four consecutive cycles; unload_done pulses after the 4th; in_ready=1.
3. Backpressure: out_ready toggled 1,0,0,1,… during unload → out_data stable while out_ready=0; no word dropped or duplicated; exactly 4 handshakes.
4. Gapped load: in_valid high only on cycles 0, 3, 4, 9 → cnt advances only on those cycles; load_done after cycle 9; no writes on the idle cycles.
5. Assert rst asynchronously after 2 words loaded (mid-cycle, no clock edge) → outputs immediately at reset values. Reload 4 words deadbeef, 01234567, 89abcdef, 0f0f0f0f → unload returns exactly these.
6. AUTO_UNLOAD=1: load 4 words → out_valid rises 2 cycles after the 4th accept, with no unload_start; in_valid during FULL/UNLOAD does not alter matrix contents.

Source files
------------

// File: rtl/aes_state_io.sv
// aes_state_io: block I/O controller for the AES state matrix.
//
// Accepts a 128-bit block as four 32-bit column words (word k -> column k)
// and writes each word into the state matrix through its column-write port.
// On request, or automatically when AUTO_UNLOAD=1, it reads the four columns
// back and streams them out. Round logic owns the matrix while this block
// is in FULL.
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   in_data/in_valid/in_ready    column-word input stream
//   load_done                    1-cycle pulse after the fourth word is written
//   unload_start                 unload request, sampled only in FULL
//   out_data/out_valid/out_ready column-word output stream
//   unload_done                  1-cycle pulse after the fourth word is handed off
//   busy                         low only when idle in LOAD with no partial block
//   mat_*                        state matrix column access port (mat_out is
//                                combinational read data for mat_idx)
module aes_state_io #(
    parameter bit AUTO_UNLOAD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        load_done,
    input  logic        unload_start,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        unload_done,
    output logic        busy,
    output logic [31:0] mat_col_in,
    output logic [1:0]  mat_idx,
    output logic        mat_row_col,
    output logic        mat_read_write,
    output logic        mat_write_enable,
    input  logic [31:0] mat_out
);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        FULL   = 2'd1,
        UNLOAD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] out_data_d;
    logic        out_valid_d;
    logic        load_done_d;
    logic        unload_done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            cnt_q       <= 2'd0;
            out_data    <= 32'd0;
            out_valid   <= 1'b0;
            load_done   <= 1'b0;
            unload_done <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_data    <= out_data_d;
            out_valid   <= out_valid_d;
            load_done   <= load_done_d;
            unload_done <= unload_done_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        out_data_d       = out_data;
        out_valid_d      = out_valid;
        load_done_d      = 1'b0;
        unload_done_d    = 1'b0;
        in_ready         = 1'b0;
        mat_row_col      = 1'b1;
        mat_read_write   = 1'b0;
        mat_write_enable = 1'b0;
        mat_col_in       = 32'd0;
        mat_idx          = cnt_q;

        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // column cnt is written in the accept cycle itself
                    mat_write_enable = 1'b1;
                    mat_read_write   = 1'b1;
                    mat_col_in       = in_data;
                    cnt_d            = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d     = FULL;
                        load_done_d = 1'b1;
                    end
                end
            end

            FULL: begin
                mat_idx = 2'd0;
                if (unload_start || AUTO_UNLOAD) begin
                    out_data_d  = mat_out;
                    out_valid_d = 1'b1;
                    cnt_d       = 2'd0;
                    state_d     = UNLOAD;
                end
            end

            UNLOAD: begin
                // Pre-address the next column so it is ready to capture on
                // the handshake; wraps to 0 on the last word (unused there).
                mat_idx = cnt_q + 2'd1;
                if (out_valid && out_ready) begin
                    if (cnt_q != 2'd3) begin
                        out_data_d = mat_out;
                        cnt_d      = cnt_q + 2'd1;
                    end else begin
                        out_valid_d   = 1'b0;
                        cnt_d         = 2'd0;
                        state_d       = LOAD;
                        unload_done_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = LOAD;
                cnt_d   = 2'd0;
            end
        endcase
    end

    assign busy = !((state_q == LOAD) && (cnt_q == 2'd0));

endmodule
